spike_mac_seq: RTL and testbench
================================

// Module: spike_mac_seq
// PURPOSE
//  Parametrised, sequential spike-gated multiply-accumulate for one SNN neuron input stage.
//  - Accepts a spike vector and a packed weight vector over a valid/ready handshake.
//  - Sums the signed weights of the spiking inputs, LANES inputs per cycle.
//  - Can carry the sum across timesteps (membrane integration).
//  - Returns the sum over a valid/ready handshake to the downstream neuron/NoC packetiser.
// PARAMETERS
//  NUM_INPUTS  4   synaptic inputs per transaction
//  WEIGHT_W    32  signed weight width
//  ACC_W       32  signed accumulator/result width; must be >= WEIGHT_W
//  LANES       1   inputs processed per cycle; NUM_INPUTS % LANES must be 0
// PORTS
//  CLK         in   1                    clock, rising edge
//  RESET_N     in   1                    asynchronous active-low reset
//  spike_in    in   NUM_INPUTS           bit i = 1: input i spiked
//  weights_in  in   NUM_INPUTS*WEIGHT_W  weight i at [i*WEIGHT_W +: WEIGHT_W], two's complement
//  in_clear    in   1                    1: start from 0; 0: start from the last result
//  in_valid    in   1                    request valid
//  in_ready    out  1                    block can accept a request
//  result      out  ACC_W                signed accumulated sum
//  overflow    out  1                    signed overflow occurred in this transaction
//  out_valid   out  1                    result/overflow valid
//  out_ready   in   1                    consumer accepts result
// BEHAVIOUR
//  - Reset (async, RESET_N=0):
//    - state=IDLE; result=0, overflow=0, out_valid=0, in_ready=1.
//    - Takes effect immediately, including mid-ACCUM or mid-DONE; the in-flight transaction is discarded.
//  - FSM: IDLE -> ACCUM -> DONE -> IDLE.
//  - IDLE:
//    - in_ready=1. On in_valid&in_ready at an edge: capture spike_in and weights_in.
//    - Load acc = in_clear ? 0 : result; clear overflow and chunk index; go to ACCUM.
//  - ACCUM:
//    - in_ready=0. Each edge adds chunk k (inputs k*LANES .. k*LANES+LANES-1); k increments.
//    - Add term = spike_i ? sign_extend(weight_i, ACC_W) : 0.
//    - After the last chunk (K = NUM_INPUTS/LANES edges), go to DONE.
//  - Latency: out_valid is high K cycles after the accept edge. Default params: K=4.
//  - Arithmetic:
//    - Two's-complement wrap modulo 2^ACC_W.
//    - overflow is sticky within the transaction: set if any single add (lane-serial within a chunk) overflows signed.
//  - DONE:
//    - out_valid=1; result/overflow held stable while out_ready=0.
//    - On out_valid&out_ready, go to IDLE. in_ready stays 0 in DONE, so no same-edge accept.
//  - result and overflow persist in IDLE until the next accept. result is the carry-in when in_clear=0.
//  - in_valid while in_ready=0 is ignored; the source must hold it. No requests are queued.
// CONFIGURATION
//  - SPIKE_MAC_SKIP_ZERO_EN defined (event-driven mode):
//    - ACCUM ends once no spike remains in the unprocessed chunks.
//    - A spike_in==0 request goes IDLE->DONE after one edge: result=carry-in, overflow=0.
//    - Latency = 1 + index of the last chunk containing a spike, minimum 1.
//  - Not defined: fixed latency K for every request. Results are identical in both modes.
// TESTING (NUM_INPUTS=4, WEIGHT_W=32, ACC_W=32, LANES=1 unless noted)
//  - Zero spikes: spike_in=4'b0000, in_clear=1, weights all 64.
//    - Required: result=0, overflow=0.
//    - out_valid 4 cycles after accept; 1 cycle with SPIKE_MAC_SKIP_ZERO_EN.
//  - Gating: spike_in=4'b0101, w0=2, w1=3, w2=5, w3=7, clear=1 -> result=7, out_valid at accept+4.
//  - Signed + carry: spike_in=4'b1111, w={-1,-2,3,4}, clear=1 -> result=4.
//    - Then spike_in=4'b0001, w0=10, clear=0 -> result=14.
//  - Overflow: spike_in=4'b0011, w0=w1=32'h7FFFFFFF, clear=1 -> result=32'hFFFFFFFE, overflow=1.
//    - Next clear=1 request -> overflow=0.
//  - Backpressure: out_ready=0 for 5 cycles in DONE.
//    - Required: result stable, in_ready=0, a new in_valid is not accepted.
//    - out_ready=1 -> IDLE next edge.
//  - Reset mid-ACCUM: drop RESET_N 2 cycles after accept.
//    - Required: out_valid=0, result=0, in_ready=1 without a clock edge.
//    - Repeat the gating case with LANES=2: result=7, latency 2.

Source files
------------

// File: rtl/spike_mac_seq.sv
// rtl/spike_mac_seq.sv - spike-gated sequential multiply-accumulate, LANES inputs per cycle
// Optional event-driven early termination: define SPIKE_MAC_SKIP_ZERO_EN.
module spike_mac_seq #(
  parameter int NUM_INPUTS = 4,
  parameter int WEIGHT_W   = 32,
  parameter int ACC_W      = 32,
  parameter int LANES      = 1
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic [NUM_INPUTS-1:0]          spike_in,
  input  logic [NUM_INPUTS*WEIGHT_W-1:0] weights_in,
  input  logic                           in_clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [ACC_W-1:0]               result,
  output logic                           overflow,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int K  = NUM_INPUTS / LANES;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

`ifdef SPIKE_MAC_SKIP_ZERO_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_e;

  state_e                         state_q;
  logic [NUM_INPUTS-1:0]          spike_q;
  logic [NUM_INPUTS*WEIGHT_W-1:0] weights_q;
  logic [ACC_W-1:0]               acc_q;
  logic                           ovf_q;
  logic [KW-1:0]                  k_q;
  logic                           in_ready_q;
  logic                           out_valid_q;

  logic [ACC_W-1:0] acc_d;
  logic             ovf_d;
  logic [ACC_W-1:0] term_d;
  logic [ACC_W-1:0] sum_d;
  logic             more_spikes_d;
  logic             last_chunk_d;

  // Captured operands are shifted down each ACCUM edge, so the current chunk always sits in the low lanes.
  // Lanes are added one after another so overflow reflects every individual add.
  always_comb begin
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    term_d = '0;
    sum_d  = acc_q;
    for (int l = 0; l < LANES; l++) begin
      term_d = spike_q[l] ? ACC_W'($signed(weights_q[l*WEIGHT_W +: WEIGHT_W])) : '0;
      sum_d  = acc_d + term_d;
      if ((acc_d[ACC_W-1] == term_d[ACC_W-1]) && (sum_d[ACC_W-1] != acc_d[ACC_W-1])) begin
        ovf_d = 1'b1;
      end
      acc_d = sum_d;
    end
  end

  // The chunk in progress is the last one when the index runs out or, in event-driven mode, no spikes remain above it.
  always_comb begin
    more_spikes_d = |(spike_q >> LANES);
    last_chunk_d  = (k_q == K_LAST) || (SKIP_ZERO && !more_spikes_d);
  end

  // Request/accumulate/response FSM with registered handshake outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      spike_q     <= '0;
      weights_q   <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            spike_q    <= spike_in;
            weights_q  <= weights_in;
            acc_q      <= in_clear ? '0 : acc_q;
            ovf_q      <= 1'b0;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc_q     <= acc_d;
          ovf_q     <= ovf_d;
          spike_q   <= spike_q >> LANES;
          weights_q <= weights_q >> (LANES * WEIGHT_W);
          k_q       <= k_q + KW'(1);
          if (last_chunk_d) begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = acc_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_spike_mac_seq.sv
// tb/tb_spike_mac_seq.sv - randomized self-checking bench for spike_mac_seq (LANES=1 and LANES=2)
module tb_spike_mac_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   spike;
  logic [127:0] weights;
  logic         clear;
  logic         in_valid;
  logic         out_ready;

  logic         in_ready1, ovf1, out_valid1;
  logic [31:0]  res1;
  logic         in_ready2, ovf2, out_valid2;
  logic [31:0]  res2;

  int           checks = 0;
  int           failures = 0;
  logic [31:0]  model_res = '0;
  logic [31:0]  last_r1;
  logic         last_o1;
  int           last_lat1;

  always #5 clk = ~clk;

  spike_mac_seq #(.NUM_INPUTS(4), .WEIGHT_W(32), .ACC_W(32), .LANES(1)) dut (
    .CLK(clk), .RESET_N(rst_n), .spike_in(spike), .weights_in(weights), .in_clear(clear),
    .in_valid(in_valid), .in_ready(in_ready1), .result(res1), .overflow(ovf1),
    .out_valid(out_valid1), .out_ready(out_ready)
  );

  spike_mac_seq #(.NUM_INPUTS(4), .WEIGHT_W(32), .ACC_W(32), .LANES(2)) dut2 (
    .CLK(clk), .RESET_N(rst_n), .spike_in(spike), .weights_in(weights), .in_clear(clear),
    .in_valid(in_valid), .in_ready(in_ready2), .result(res2), .overflow(ovf2),
    .out_valid(out_valid2), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer sum with range test after every spiking add, then wrap.
  function automatic void model(input logic [3:0] sp, input logic [127:0] w, input logic clr,
                                input int lanes, output logic [31:0] r, output logic o, output int lat);
    longint a;
    int last;
    a = clr ? 64'sd0 : longint'($signed(model_res));
    o = 1'b0;
    last = -1;
    for (int i = 0; i < 4; i++) begin
      if (sp[i]) begin
        a = a + longint'($signed(w[i*32 +: 32]));
        if (a > 64'sd2147483647 || a < -64'sd2147483648) begin
          o = 1'b1;
          a = longint'($signed(a[31:0]));
        end
        last = i / lanes;
      end
    end
    r = a[31:0];
`ifdef SPIKE_MAC_SKIP_ZERO_EN
    lat = (last < 0) ? 1 : last + 1;
`else
    lat = 4 / lanes;
`endif
  endfunction

  task automatic do_txn(input logic [3:0] sp, input logic [127:0] w, input logic clr, input string tag);
    logic [31:0] er, er2, r1, r2;
    logic eo, eo2, o1, o2;
    int el1, el2;
    int lat1 = -1;
    int lat2 = -1;
    model(sp, w, clr, 1, er, eo, el1);
    model(sp, w, clr, 2, er2, eo2, el2);
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready1, 1'b1);
    spike = sp; weights = w; clear = clr; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 20 && (lat1 < 0 || lat2 < 0); c++) begin
      @(negedge clk);
      if (lat1 < 0 && out_valid1) begin lat1 = c; r1 = res1; o1 = ovf1; end
      if (lat2 < 0 && out_valid2) begin lat2 = c; r2 = res2; o2 = ovf2; end
    end
    check({tag, "_lat1"}, lat1, el1);
    check({tag, "_res1"}, r1, er);
    check({tag, "_ovf1"}, o1, eo);
    check({tag, "_lat2"}, lat2, el2);
    check({tag, "_res2"}, r2, er2);
    check({tag, "_ovf2"}, o2, eo2);
    last_r1 = r1; last_o1 = o1; last_lat1 = lat1;
    model_res = er;
  endtask

  task automatic backpressure_test();
    logic [31:0] er;
    logic eo;
    int el;
    int seen = 0;
    logic [127:0] w;
    w = {32'd7, 32'd5, 32'd3, 32'd2};
    model(4'b0101, w, 1'b1, 1, er, eo, el);
    @(negedge clk);
    spike = 4'b0101; weights = w; clear = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (out_valid1) seen = 1;
    end
    check("bp_done_reached", seen, 1);
    in_valid = 1'b1; spike = 4'b1111; clear = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_res_stable", res1, er);
      check("bp_in_ready", in_ready1, 1'b0);
      check("bp_out_valid", out_valid1, 1'b1);
      check("bp_res2_stable", res2, er);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", out_valid1, 1'b0);
    check("bp_release_ready", in_ready1, 1'b1);
    check("bp_release_res", res1, er);
    check("bp_release_ready2", in_ready2, 1'b1);
    model_res = er;
  endtask

  task automatic reset_mid_accum_test();
    @(negedge clk);
    spike = 4'b1111; weights = {32'd40, 32'd30, 32'd20, 32'd10}; clear = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid1, 1'b0);
    check("rst_mid_res", res1, 32'd0);
    check("rst_mid_in_ready", in_ready1, 1'b1);
    check("rst_mid_out_valid2", out_valid2, 1'b0);
    check("rst_mid_res2", res2, 32'd0);
    check("rst_mid_in_ready2", in_ready2, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    model_res = '0;
  endtask

  initial begin
    logic [127:0] w;
    logic [31:0]  wv;
    rst_n = 1'b0; spike = '0; weights = '0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    check("reset_in_ready", in_ready1, 1'b1);
    check("reset_out_valid", out_valid1, 1'b0);
    check("reset_result", res1, 32'd0);
    check("reset_overflow", ovf1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    do_txn(4'b0000, {4{32'd64}}, 1'b1, "zero");
    check("zero_res_spec", last_r1, 32'd0);
    do_txn(4'b0101, {32'd7, 32'd5, 32'd3, 32'd2}, 1'b1, "gate");
    check("gate_res_spec", last_r1, 32'd7);
    do_txn(4'b1111, {32'd4, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF}, 1'b1, "signed");
    check("signed_res_spec", last_r1, 32'd4);
    do_txn(4'b0001, {32'd0, 32'd0, 32'd0, 32'd10}, 1'b0, "carry");
    check("carry_res_spec", last_r1, 32'd14);
    do_txn(4'b0011, {32'd0, 32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF}, 1'b1, "ovf");
    check("ovf_res_spec", last_r1, 32'hFFFF_FFFE);
    check("ovf_flag_spec", last_o1, 1'b1);
    do_txn(4'b0101, {32'd7, 32'd5, 32'd3, 32'd2}, 1'b1, "ovf_clear");
    check("ovf_clear_spec", last_o1, 1'b0);
    do_txn(4'b0001, {32'd0, 32'd0, 32'd0, 32'h8000_0000}, 1'b0, "neg_carry");

    backpressure_test();
    reset_mid_accum_test();
    do_txn(4'b0101, {32'd7, 32'd5, 32'd3, 32'd2}, 1'b1, "gate_after_rst");

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) begin
        wv = ($urandom_range(0, 2) == 0) ? $urandom : ($urandom_range(0, 2000) - 32'd1000);
        w[i*32 +: 32] = wv;
      end
      do_txn(4'($urandom_range(0, 15)), w, 1'($urandom_range(0, 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
